msg_mem_fetcher: RTL and testbench

//  Memory-side responder to the decoder control FSM. Takes the control strobes
//  (vr_process, circ_node, neighbor, syndrome) and turns them into message-RAM

---
 rtl/msg_mem_fetcher.sv | 140 ++++++++++++++
 tb/tb_msg_mem_fetcher.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_mem_fetcher.sv
// msg_mem_fetcher: message-RAM responder for the decoder control FSM.
// A neighbor request reads one circulant's messages on NPORT parallel ports,
// presents them to the processing unit, and writes the returned results back
// to the same addresses. A syndrome request reads the sign bits of one row
// and reports whether their parity is even.
// Handshake: pu_data is offered with pu_valid and transfers on the cycle
// where pu_valid && pu_ready. pu_data stays stable until then.
// pu_result is taken on the single cycle pu_result_valid is high while the
// block waits for it.
module msg_mem_fetcher #(
    parameter int NPORT         = 9,
    parameter int CIRC_SIZE     = 3,
    parameter int LOG2CIRC_SIZE = 2,
    parameter int ADDR_WIDTH    = 5,
    parameter int BUS_WIDTH     = 6,
    parameter logic [NPORT*LOG2CIRC_SIZE-1:0] SHIFTS = 18'h24924
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         vr_process,
    input  logic [LOG2CIRC_SIZE-1:0]     circ_node,
    input  logic                         neighbor,
    input  logic                         syndrome,
    output logic                         busy,
    output logic [NPORT*ADDR_WIDTH-1:0]  mf_addr,
    input  logic [NPORT*BUS_WIDTH-1:0]   mf_rdata,
    output logic [NPORT*BUS_WIDTH-1:0]   mf_wdata,
    output logic [NPORT-1:0]             mf_we,
    output logic [NPORT*BUS_WIDTH-1:0]   pu_data,
    output logic                         pu_valid,
    input  logic                         pu_ready,
    input  logic [NPORT*BUS_WIDTH-1:0]   pu_result,
    input  logic                         pu_result_valid,
    output logic                         done,
    output logic                         synd_valid,
    output logic                         synd_ok
);

    localparam int CW = LOG2CIRC_SIZE;
    localparam int AW = ADDR_WIDTH;
    localparam int BW = BUS_WIDTH;
    localparam logic [CW:0] CS_W = (CW+1)'(CIRC_SIZE);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RD       = 4'd1,
        CAP      = 4'd2,
        PRESENT  = 4'd3,
        WAIT_RES = 4'd4,
        WB       = 4'd5,
        DONE     = 4'd6,
        S_RD     = 4'd7,
        S_CAP    = 4'd8
    } state_t;

    state_t                  state_q, state_d;
    logic [NPORT*AW-1:0]     addr_q;
    logic [NPORT*BW-1:0]     pu_data_q;
    logic [NPORT*BW-1:0]     wdata_q;
    logic                    synd_ok_q;

    logic                    node_ok;
    logic                    accept_nb;
    logic                    accept_sy;
    logic                    use_shift;
    logic [NPORT*AW-1:0]     addr_new;
    logic [NPORT-1:0]        sign_bits;

    // Out-of-range rows are dropped; neighbor has priority over syndrome.
    assign node_ok   = ({1'b0, circ_node} < CS_W);
    assign accept_nb = (state_q == IDLE) && neighbor && node_ok;
    assign accept_sy = (state_q == IDLE) && !neighbor && syndrome && node_ok;
    // Only a check-node neighbor pass applies the circulant shift.
    assign use_shift = neighbor && !vr_process;

    for (genvar k = 0; k < NPORT; k++) begin : g_port
        localparam logic [CW:0]   SHIFT_K = {1'b0, SHIFTS[k*CW +: CW]};
        localparam logic [AW-1:0] BASE_K  = AW'(k * CIRC_SIZE);
        logic [CW:0] sum_k;
        logic [CW:0] idx_k;
        // Both operands are below CIRC_SIZE, so one subtract wraps the sum.
        assign sum_k = {1'b0, circ_node} + SHIFT_K;
        assign idx_k = !use_shift ? {1'b0, circ_node}
                     : (sum_k >= CS_W) ? (sum_k - CS_W) : sum_k;
        assign addr_new[k*AW +: AW] = BASE_K + AW'(idx_k);
        assign sign_bits[k] = mf_rdata[k*BW + BW - 1];
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic for both the neighbor and syndrome sequences.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_nb)      state_d = RD;
                else if (accept_sy) state_d = S_RD;
            end
            RD:       state_d = CAP;
            CAP:      state_d = PRESENT;
            PRESENT:  if (pu_ready) state_d = WAIT_RES;
            WAIT_RES: if (pu_result_valid) state_d = WB;
            WB:       state_d = DONE;
            DONE:     state_d = IDLE;
            S_RD:     state_d = S_CAP;
            S_CAP:    state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Datapath registers: address on acceptance, read data, write data, parity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            pu_data_q <= '0;
            wdata_q   <= '0;
            synd_ok_q <= 1'b0;
        end else begin
            if (accept_nb || accept_sy)                  addr_q    <= addr_new;
            if (state_q == CAP)                          pu_data_q <= mf_rdata;
            if (state_q == WAIT_RES && pu_result_valid)  wdata_q   <= pu_result;
            if (state_q == S_CAP)                        synd_ok_q <= ~^sign_bits;
        end
    end

    assign busy       = (state_q != IDLE);
    assign mf_addr    = addr_q;
    assign mf_wdata   = wdata_q;
    assign mf_we      = {NPORT{state_q == WB}};
    assign pu_data    = pu_data_q;
    assign pu_valid   = (state_q == PRESENT);
    assign done       = (state_q == DONE);
    assign synd_valid = (state_q == S_CAP);
    assign synd_ok    = (state_q == S_CAP) ? ~^sign_bits : synd_ok_q;

endmodule

// File: tb/tb_msg_mem_fetcher.sv
// Testbench for msg_mem_fetcher: a message RAM model, table-driven neighbor
// vectors, hand-written corner sequences and randomized transactions checked
// against an arithmetic model of addresses, fetched data and parity.
module tb_msg_mem_fetcher;

    localparam int NPORT = 9;
    localparam int CS    = 3;
    localparam int CW    = 2;
    localparam int AW    = 5;
    localparam int BW    = 6;
    localparam int NA    = NPORT * AW;
    localparam int NB    = NPORT * BW;
    localparam logic [NPORT*CW-1:0] SHIFTS = 18'h24924;

    // ---------------- clock / reset and DUT signals ----------------
    logic            clk = 1'b0;
    logic            rst;
    logic            vr_process;
    logic [CW-1:0]   circ_node;
    logic            neighbor;
    logic            syndrome;
    logic            busy;
    logic [NA-1:0]   mf_addr;
    logic [NB-1:0]   mf_rdata;
    logic [NB-1:0]   mf_wdata;
    logic [NPORT-1:0] mf_we;
    logic [NB-1:0]   pu_data;
    logic            pu_valid;
    logic            pu_ready;
    logic [NB-1:0]   pu_result;
    logic            pu_result_valid;
    logic            done;
    logic            synd_valid;
    logic            synd_ok;

    always #5 clk = ~clk;

    msg_mem_fetcher #(
        .NPORT(NPORT), .CIRC_SIZE(CS), .LOG2CIRC_SIZE(CW),
        .ADDR_WIDTH(AW), .BUS_WIDTH(BW), .SHIFTS(SHIFTS)
    ) dut (
        .clk(clk), .rst(rst), .vr_process(vr_process), .circ_node(circ_node),
        .neighbor(neighbor), .syndrome(syndrome), .busy(busy),
        .mf_addr(mf_addr), .mf_rdata(mf_rdata), .mf_wdata(mf_wdata), .mf_we(mf_we),
        .pu_data(pu_data), .pu_valid(pu_valid), .pu_ready(pu_ready),
        .pu_result(pu_result), .pu_result_valid(pu_result_valid),
        .done(done), .synd_valid(synd_valid), .synd_ok(synd_ok)
    );

    // ---------------- message RAM model (sync read, 1-cycle latency) ----------------
    logic [BW-1:0] mem [0:31];
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [BW-1:0] ld_data;

    always @(posedge clk) begin
        for (int k = 0; k < NPORT; k++) begin
            mf_rdata[k*BW +: BW] <= mem[mf_addr[k*AW +: AW]];
            if (mf_we[k]) mem[mf_addr[k*AW +: AW]] <= mf_wdata[k*BW +: BW];
        end
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    // ---------------- reference model ----------------
    logic [BW-1:0] exp_mem [0:31];
    logic [NA-1:0] last_addr;
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [NA-1:0] model_addr(input logic vr, input int node, input logic synd);
        logic [NA-1:0] r;
        logic [NPORT*CW-1:0] sh_all;
        int sh, idx;
        r = '0;
        sh_all = SHIFTS;
        for (int k = 0; k < NPORT; k++) begin
            sh  = int'((sh_all >> (k * CW)) & ((1 << CW) - 1));
            idx = (vr || synd) ? node : (node + sh) % CS;
            r[k*AW +: AW] = AW'(k * CS + idx);
        end
        return r;
    endfunction

    function automatic logic [NB-1:0] model_fetch(input logic [NA-1:0] ea);
        logic [NB-1:0] d;
        for (int k = 0; k < NPORT; k++) d[k*BW +: BW] = exp_mem[ea[k*AW +: AW]];
        return d;
    endfunction

    function automatic logic model_parity_even(input logic [NA-1:0] ea);
        int cnt;
        cnt = 0;
        for (int k = 0; k < NPORT; k++) cnt += int'(exp_mem[ea[k*AW +: AW]][BW-1]);
        return (cnt % 2) == 0;
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic load_mem(input int a, input logic [BW-1:0] d);
        ld_en = 1'b1; ld_addr = AW'(a); ld_data = d;
        step();
        ld_en = 1'b0;
        exp_mem[a] = d;
    endtask

    task automatic run_neighbor(input logic vr, input logic [CW-1:0] node, input logic [NA-1:0] ea,
                                input int hold, input int dly, input logic with_synd, input logic poke);
        logic [NB-1:0] exp_pd;
        logic [NB-1:0] res;
        exp_pd = model_fetch(ea);
        vr_process = vr; circ_node = node; neighbor = 1'b1; syndrome = with_synd;
        step();                                   // RD
        neighbor = 1'b0; syndrome = 1'b0;
        check("nb_busy", 64'(busy), 64'd1);
        check("nb_addr", 64'(mf_addr), 64'(ea));
        check("nb_pvalid_rd", 64'(pu_valid), 64'd0);
        step();                                   // CAP
        check("nb_pvalid_cap", 64'(pu_valid), 64'd0);
        check("nb_no_synd", 64'(synd_valid), 64'd0);
        step();                                   // PRESENT
        check("nb_pvalid", 64'(pu_valid), 64'd1);
        check("nb_pdata", 64'(pu_data), 64'(exp_pd));
        for (int i = 0; i < hold; i++) begin
            step();
            check("nb_hold_valid", 64'(pu_valid), 64'd1);
            check("nb_hold_data", 64'(pu_data), 64'(exp_pd));
        end
        pu_ready = 1'b1;
        step();                                   // WAIT_RES
        pu_ready = 1'b0;
        check("nb_pvalid_drop", 64'(pu_valid), 64'd0);
        for (int i = 0; i < dly; i++) begin
            check("nb_wait_we", 64'(mf_we), 64'd0);
            step();
        end
        res = NB'({$urandom(), $urandom()});
        pu_result = res; pu_result_valid = 1'b1;
        check("nb_wait_we", 64'(mf_we), 64'd0);
        step();                                   // WB
        pu_result_valid = 1'b0; pu_result = NB'({$urandom(), $urandom()});
        check("wb_we", 64'(mf_we), 64'h1FF);
        check("wb_wdata", 64'(mf_wdata), 64'(res));
        check("wb_addr", 64'(mf_addr), 64'(ea));
        check("wb_done", 64'(done), 64'd0);
        step();                                   // DONE
        check("done_pulse", 64'(done), 64'd1);
        check("done_we", 64'(mf_we), 64'd0);
        if (poke) neighbor = 1'b1;
        step();                                   // IDLE
        neighbor = 1'b0;
        check("done_low", 64'(done), 64'd0);
        check("end_busy", 64'(busy), 64'd0);
        if (poke) begin
            step();
            check("poke_ignored", 64'(busy), 64'd0);
        end
        for (int k = 0; k < NPORT; k++) exp_mem[ea[k*AW +: AW]] = res[k*BW +: BW];
        last_addr = ea;
    endtask

    task automatic run_syndrome(input logic [CW-1:0] node);
        logic [NA-1:0] ea;
        logic ok;
        ea = model_addr(1'b0, int'(node), 1'b1);
        ok = model_parity_even(ea);
        circ_node = node; syndrome = 1'b1; vr_process = $urandom_range(0, 1) != 0;
        step();                                   // S_RD
        syndrome = 1'b0;
        check("sy_busy", 64'(busy), 64'd1);
        check("sy_addr", 64'(mf_addr), 64'(ea));
        check("sy_valid_rd", 64'(synd_valid), 64'd0);
        step();                                   // S_CAP
        check("sy_valid", 64'(synd_valid), 64'd1);
        check("sy_ok", 64'(synd_ok), 64'(ok));
        check("sy_no_pu", 64'(pu_valid), 64'd0);
        step();                                   // IDLE
        check("sy_valid_low", 64'(synd_valid), 64'd0);
        check("sy_ok_hold", 64'(synd_ok), 64'(ok));
        check("sy_end_busy", 64'(busy), 64'd0);
        last_addr = ea;
    endtask

    task automatic run_bad_node(input logic nb);
        vr_process = $urandom_range(0, 1) != 0; circ_node = 2'd3;
        neighbor = nb; syndrome = !nb;
        step();
        neighbor = 1'b0; syndrome = 1'b0;
        check("bad_busy", 64'(busy), 64'd0);
        check("bad_addr", 64'(mf_addr), 64'(last_addr));
        step();
        check("bad_busy2", 64'(busy), 64'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          vr;
        logic [CW-1:0] node;
        logic [NA-1:0] addr;
        int            hold;
        int            dly;
        logic          with_synd;
        logic          poke;
    } vec_t;

    vec_t vecs [4];

    // ---------------- main sequence ----------------
    initial begin
        logic [BW-1:0] d;
        int op;
        vecs[0] = '{1'b0, 2'd2, {5'd25, 5'd21, 5'd20, 5'd16, 5'd12, 5'd11, 5'd7, 5'd3, 5'd2}, 0, 0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 2'd1, {5'd25, 5'd22, 5'd19, 5'd16, 5'd13, 5'd10, 5'd7, 5'd4, 5'd1}, 5, 1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 2'd0, {5'd26, 5'd22, 5'd18, 5'd17, 5'd13, 5'd9, 5'd8, 5'd4, 5'd0}, 1, 2, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 2'd1, {5'd24, 5'd23, 5'd19, 5'd15, 5'd14, 5'd10, 5'd6, 5'd5, 5'd1}, 2, 0, 1'b0, 1'b1};

        rst = 1'b1; vr_process = 1'b0; circ_node = '0; neighbor = 1'b0; syndrome = 1'b0;
        pu_ready = 1'b0; pu_result = '0; pu_result_valid = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        last_addr = '0;
        for (int a = 0; a < 32; a++) exp_mem[a] = '0;
        step();
        step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_addr", 64'(mf_addr), 64'd0);
        check("rst_we", 64'(mf_we), 64'd0);
        check("rst_pvalid", 64'(pu_valid), 64'd0);
        check("rst_pdata", 64'(pu_data), 64'd0);
        check("rst_wdata", 64'(mf_wdata), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_svalid", 64'(synd_valid), 64'd0);
        check("rst_sok", 64'(synd_ok), 64'd0);
        rst = 1'b0;
        step();

        // Preload RAM; row 0 sign bits are 1,1,0,0,0,0,0,0,0.
        for (int a = 0; a < NPORT * CS; a++) begin
            d = BW'($urandom_range(0, 63));
            if (a % CS == 0) d[BW-1] = (a / CS) < 2;
            load_mem(a, d);
        end
        for (int a = NPORT * CS; a < 32; a++) load_mem(a, '0);

        // Syndrome on row 0: even, then odd after flipping port 2, then even again.
        run_syndrome(2'd0);
        check("t4_ok_even", 64'(synd_ok), 64'd1);
        load_mem(6, exp_mem[6] ^ 6'h20);
        run_syndrome(2'd0);
        check("t4_ok_odd", 64'(synd_ok), 64'd0);
        load_mem(6, exp_mem[6] ^ 6'h20);
        run_syndrome(2'd0);

        // Reset asserted while data is being presented.
        vr_process = 1'b0; circ_node = 2'd2; neighbor = 1'b1;
        step();
        neighbor = 1'b0;
        step();
        step();
        check("mid_pvalid_pre", 64'(pu_valid), 64'd1);
        step();
        rst = 1'b1;
        #1;
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_pvalid", 64'(pu_valid), 64'd0);
        check("mid_pdata", 64'(pu_data), 64'd0);
        check("mid_addr", 64'(mf_addr), 64'd0);
        check("mid_we", 64'(mf_we), 64'd0);
        check("mid_sok", 64'(synd_ok), 64'd0);
        step();
        check("mid_we2", 64'(mf_we), 64'd0);
        rst = 1'b0;
        step();
        check("mid_busy_after", 64'(busy), 64'd0);
        check("mid_we_after", 64'(mf_we), 64'd0);
        last_addr = '0;

        // Out-of-range row is dropped for both request kinds.
        run_bad_node(1'b1);
        run_bad_node(1'b0);

        // Table-driven neighbor transactions.
        for (int i = 0; i < 4; i++)
            run_neighbor(vecs[i].vr, vecs[i].node, vecs[i].addr, vecs[i].hold,
                         vecs[i].dly, vecs[i].with_synd, vecs[i].poke);

        // Randomized transactions against the model.
        for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 4);
            if (op == 0) begin
                run_syndrome(CW'($urandom_range(0, CS - 1)));
            end else if (op == 4) begin
                run_bad_node($urandom_range(0, 1) != 0);
            end else begin
                logic vr;
                int node;
                vr   = $urandom_range(0, 1) != 0;
                node = $urandom_range(0, CS - 1);
                run_neighbor(vr, CW'(node), model_addr(vr, node, 1'b0),
                             $urandom_range(0, 3), $urandom_range(0, 3),
                             $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
            end
        end

        // RAM contents must equal the model after every write-back.
        begin
            int bad;
            bad = 0;
            for (int a = 0; a < NPORT * CS; a++) if (mem[a] !== exp_mem[a]) bad++;
            check("mem_final_bad_entries", 64'(bad), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
